// File: rtl/shift_pkg.sv
// Shared encodings for the shift arbiter and the barrel shifter core.
package shift_pkg;

  localparam int SH_W = 32;

  // Request-side operation codes; 5..7 are reserved and flagged as errors.
  typedef enum logic [2:0] {
    SHOP_SLL = 3'd0,
    SHOP_SRL = 3'd1,
    SHOP_SRA = 3'd2,
    SHOP_ROR = 3'd3,
    SHOP_ROL = 3'd4
  } shop_e;

  // Operation codes understood by the shifter core.
  typedef enum logic [1:0] {
    CORE_SLL = 2'b00,
    CORE_SRL = 2'b01,
    CORE_SRA = 2'b10,
    CORE_ROR = 2'b11
  } core_op_e;

  // Contents of the one-entry response buffer.
  typedef struct packed {
    logic [SH_W-1:0] data;
    logic            id;
    logic            err;
  } resp_t;

  // Rotate-left by n equals rotate-right by (32 - n), wrapped to 5 bits.
  function automatic logic [4:0] rol_to_ror(input logic [4:0] amt);
    return 5'd0 - amt;
  endfunction

endpackage

// File: rtl/shift_arbiter_if.sv
// Request/response bundle between the issue logic and the shift arbiter.
interface shift_arbiter_if #(
  parameter int W     = 32,
  parameter int CNT_W = 16
);
  logic [1:0]       req_valid;
  logic [1:0]       req_ready;
  logic [W-1:0]     req0_data;
  logic [W-1:0]     req1_data;
  logic [2:0]       req0_op;
  logic [2:0]       req1_op;
  logic [4:0]       req0_amt;
  logic [4:0]       req1_amt;
  logic             resp_valid;
  logic             resp_ready;
  logic [W-1:0]     resp_data;
  logic             resp_id;
  logic             resp_err;
  logic [CNT_W-1:0] stat_grant0;
  logic [CNT_W-1:0] stat_grant1;

  modport slave (
    input  req_valid, req0_data, req1_data, req0_op, req1_op, req0_amt, req1_amt, resp_ready,
    output req_ready, resp_valid, resp_data, resp_id, resp_err, stat_grant0, stat_grant1
  );

  modport master (
    output req_valid, req0_data, req1_data, req0_op, req1_op, req0_amt, req1_amt, resp_ready,
    input  req_ready, resp_valid, resp_data, resp_id, resp_err, stat_grant0, stat_grant1
  );
endinterface

// File: rtl/rr_arb2.sv
// Two-input round-robin arbiter; last_grant resets to 1 so requester 0 wins the first tie.
module rr_arb2 (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req_i,
  input  logic       advance_i,
  output logic       grant_valid_o,
  output logic       grant_id_o
);

  logic last_grant_q, last_grant_d;

  // Grant selection: a lone requester wins, a tie goes to the one not served last.
  always_comb begin
    grant_valid_o = |req_i;
    case (req_i)
      2'b10:   grant_id_o = 1'b1;
      2'b11:   grant_id_o = ~last_grant_q;
      default: grant_id_o = 1'b0;
    endcase
    last_grant_d = advance_i ? grant_id_o : last_grant_q;
  end

  // Remember the last requester that actually transferred.
  always_ff @(posedge clk) begin
    if (reset) last_grant_q <= 1'b1;
    else       last_grant_q <= last_grant_d;
  end

endmodule

// File: rtl/shift_core.sv
// Combinational 32-bit barrel shifter core (SLL/SRL/SRA/ROR).
module shift_core
  import shift_pkg::*;
(
  input  logic [SH_W-1:0] data,
  input  logic [1:0]      shift_op,
  input  logic [4:0]      SA,
  output logic [SH_W-1:0] result
);

  // Rotate uses a 6-bit complement so SA=0 shifts the left half fully out.
  always_comb begin
    case (shift_op)
      CORE_SLL: result = data << SA;
      CORE_SRL: result = data >> SA;
      CORE_SRA: result = $signed(data) >>> SA;
      default:  result = (data >> SA) | (data << (6'd32 - {1'b0, SA}));
    endcase
  end

endmodule

// File: rtl/shift_arbiter.sv
// Shares one barrel shifter between two requesters with round-robin arbitration,
// ROL-to-ROR conversion and a one-entry valid/ready response buffer.
// Optional grant statistics counters are built when SHIFT_ARB_STATS_EN is defined.
module shift_arbiter
  import shift_pkg::*;
#(
  parameter int W     = SH_W,
  parameter int CNT_W = 16
) (
  input logic            clk,
  input logic            reset,
  shift_arbiter_if.slave bus
);

  logic         grant_valid, grant_id, can_accept, accept;
  logic [1:0]   req_ready;
  logic [W-1:0] sel_data;
  logic [2:0]   sel_op;
  logic [4:0]   sel_amt;
  core_op_e     core_op;
  logic [4:0]   core_sa;
  logic         op_err;
  logic [W-1:0] core_result;
  resp_t        resp_q, resp_d;
  logic         resp_valid_q, resp_valid_d;

  rr_arb2 u_arb (
    .clk           (clk),
    .reset         (reset),
    .req_i         (bus.req_valid),
    .advance_i     (accept),
    .grant_valid_o (grant_valid),
    .grant_id_o    (grant_id)
  );

  // Handshake: accept whenever the buffer is empty or being drained this cycle.
  always_comb begin
    can_accept = !resp_valid_q || bus.resp_ready;
    accept     = can_accept && grant_valid;
    req_ready  = 2'b00;
    if (accept) req_ready[grant_id] = 1'b1;
  end

  // Route the granted requester's operands to the shared shifter.
  always_comb begin
    sel_data = grant_id ? bus.req1_data : bus.req0_data;
    sel_op   = grant_id ? bus.req1_op   : bus.req0_op;
    sel_amt  = grant_id ? bus.req1_amt  : bus.req0_amt;
  end

  // Translate request op to core op; ROL becomes ROR with a complemented amount.
  always_comb begin
    core_op = CORE_SLL;
    core_sa = sel_amt;
    op_err  = 1'b0;
    case (sel_op)
      SHOP_SLL: core_op = CORE_SLL;
      SHOP_SRL: core_op = CORE_SRL;
      SHOP_SRA: core_op = CORE_SRA;
      SHOP_ROR: core_op = CORE_ROR;
      SHOP_ROL: begin
        core_op = CORE_ROR;
        core_sa = rol_to_ror(sel_amt);
      end
      default:  op_err = 1'b1;
    endcase
  end

  shift_core u_core (
    .data     (sel_data),
    .shift_op (core_op),
    .SA       (core_sa),
    .result   (core_result)
  );

  // Response buffer next state: load on accept (also covers pop+push), clear on pop only.
  always_comb begin
    resp_d       = resp_q;
    resp_valid_d = resp_valid_q;
    if (accept) begin
      resp_valid_d = 1'b1;
      resp_d.data  = op_err ? '0 : core_result;
      resp_d.id    = grant_id;
      resp_d.err   = op_err;
    end else if (bus.resp_ready) begin
      resp_valid_d = 1'b0;
    end
  end

  // Response buffer registers; reset drops any buffered result.
  always_ff @(posedge clk) begin
    if (reset) begin
      resp_valid_q <= 1'b0;
      resp_q       <= '0;
    end else begin
      resp_valid_q <= resp_valid_d;
      resp_q       <= resp_d;
    end
  end

  assign bus.req_ready  = req_ready;
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_data  = resp_q.data;
  assign bus.resp_id    = resp_q.id;
  assign bus.resp_err   = resp_q.err;

`ifdef SHIFT_ARB_STATS_EN
  logic [CNT_W-1:0] stat0_q, stat0_d, stat1_q, stat1_d;
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  // Saturating grant counters.
  always_comb begin
    stat0_d = stat0_q;
    stat1_d = stat1_q;
    if (accept && !grant_id && !(&stat0_q)) stat0_d = stat0_q + CNT_ONE;
    if (accept &&  grant_id && !(&stat1_q)) stat1_d = stat1_q + CNT_ONE;
  end

  // Counter registers cleared by reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      stat0_q <= '0;
      stat1_q <= '0;
    end else begin
      stat0_q <= stat0_d;
      stat1_q <= stat1_d;
    end
  end

  assign bus.stat_grant0 = stat0_q;
  assign bus.stat_grant1 = stat1_q;
`else
  assign bus.stat_grant0 = {CNT_W{1'b0}};
  assign bus.stat_grant1 = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_shift_arbiter.sv
// Directed bench for shift_arbiter with a response scoreboard.
module tb_shift_arbiter;
  import shift_pkg::*;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  shift_arbiter_if bus ();
  shift_arbiter dut (.clk(clk), .reset(reset), .bus(bus));

  typedef struct {
    logic        id;
    logic        err;
    logic [31:0] data;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int errors = 0;

  logic [31:0] exp0_data, exp1_data;
  logic        exp0_err, exp1_err;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, req);
    end
  endtask

  task automatic set_req(input int r, input logic [31:0] d, input logic [2:0] op,
                         input logic [4:0] amt, input logic [31:0] ed, input logic ee);
    if (r == 0) begin
      bus.req0_data = d; bus.req0_op = op; bus.req0_amt = amt;
      exp0_data = ed; exp0_err = ee;
    end else begin
      bus.req1_data = d; bus.req1_op = op; bus.req1_amt = amt;
      exp1_data = ed; exp1_err = ee;
    end
  endtask

  // Entered and left at posedge+1; inputs held for one full cycle.
  task automatic cyc(input logic [1:0] v, input logic rr, input logic [1:0] er, input string name);
    bus.req_valid  = v;
    bus.resp_ready = rr;
    @(negedge clk);
    chk(name, {30'b0, bus.req_ready}, {30'b0, er});
    if (er == 2'b01) sb.push_back('{1'b0, exp0_err, exp0_data});
    else if (er == 2'b10) sb.push_back('{1'b1, exp1_err, exp1_data});
    @(posedge clk);
    #1;
  endtask

  // Monitor: every response popped by the consumer is compared with the scoreboard head.
  always @(negedge clk) begin
    if (!reset && bus.resp_valid && bus.resp_ready) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_resp: got data 0x%08h id %0d, expected no response",
                 bus.resp_data, bus.resp_id);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("resp_data", bus.resp_data, e.data);
        chk("resp_id", {31'b0, bus.resp_id}, {31'b0, e.id});
        chk("resp_err", {31'b0, bus.resp_err}, {31'b0, e.err});
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1;
    bus.req_valid = 2'b00;
    bus.resp_ready = 1'b0;
    set_req(0, 32'h0, 3'd0, 5'd0, 32'h0, 1'b0);
    set_req(1, 32'h0, 3'd0, 5'd0, 32'h0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;

    chk("rst_resp_valid", {31'b0, bus.resp_valid}, 32'h0);
    chk("rst_resp_data", bus.resp_data, 32'h0);
    chk("rst_resp_id", {31'b0, bus.resp_id}, 32'h0);
    chk("rst_resp_err", {31'b0, bus.resp_err}, 32'h0);
    chk("rst_stat0", {16'b0, bus.stat_grant0}, 32'h0);
    chk("rst_stat1", {16'b0, bus.stat_grant1}, 32'h0);

    // Single SLL from requester 0, one-cycle latency.
    set_req(0, 32'h0000_0001, 3'd0, 5'd4, 32'h0000_0010, 1'b0);
    cyc(2'b01, 1'b1, 2'b01, "rdy_sll");
    chk("latency_valid", {31'b0, bus.resp_valid}, 32'h1);
    cyc(2'b00, 1'b1, 2'b00, "rdy_idle0");

    // Requester 1: SRA, ROL 1, ROL 10.
    set_req(1, 32'h8000_0000, 3'd2, 5'd31, 32'hFFFF_FFFF, 1'b0);
    cyc(2'b10, 1'b1, 2'b10, "rdy_sra");
    set_req(1, 32'h8000_0001, 3'd4, 5'd1, 32'h0000_0003, 1'b0);
    cyc(2'b10, 1'b1, 2'b10, "rdy_rol1");
    set_req(1, 32'h0000_0001, 3'd4, 5'd10, 32'h0000_0400, 1'b0);
    cyc(2'b10, 1'b1, 2'b10, "rdy_rol10");
    cyc(2'b00, 1'b1, 2'b00, "rdy_idle1");

    // Both requesting with resp_ready=1: strict alternation starting at 0.
    set_req(0, 32'hF000_0000, 3'd1, 5'd4, 32'h0F00_0000, 1'b0);
    set_req(1, 32'h0000_00F1, 3'd3, 5'd4, 32'h1000_000F, 1'b0);
    for (int i = 0; i < 6; i++)
      cyc(2'b11, 1'b1, (i % 2 == 0) ? 2'b01 : 2'b10, "rdy_alt");

    // Back-pressure: nothing accepted, buffer held.
    for (int i = 0; i < 3; i++) begin
      cyc(2'b11, 1'b0, 2'b00, "rdy_stall");
      chk("stall_valid", {31'b0, bus.resp_valid}, 32'h1);
      chk("stall_data", bus.resp_data, 32'h1000_000F);
      chk("stall_id", {31'b0, bus.resp_id}, 32'h1);
    end
    cyc(2'b11, 1'b1, 2'b01, "rdy_resume");
    cyc(2'b00, 1'b1, 2'b00, "rdy_idle2");

    // Reserved op and ROL by 0.
    set_req(0, 32'hDEAD_BEEF, 3'd7, 5'd3, 32'h0000_0000, 1'b1);
    cyc(2'b01, 1'b1, 2'b01, "rdy_resv");
    cyc(2'b00, 1'b1, 2'b00, "rdy_resv_once");
    set_req(0, 32'h1234_5678, 3'd4, 5'd0, 32'h1234_5678, 1'b0);
    cyc(2'b01, 1'b1, 2'b01, "rdy_rol0");
    cyc(2'b00, 1'b1, 2'b00, "rdy_idle3");

`ifdef SHIFT_ARB_STATS_EN
    chk("stat0_count", {16'b0, bus.stat_grant0}, 32'd7);
    chk("stat1_count", {16'b0, bus.stat_grant1}, 32'd6);
`else
    chk("stat0_tied", {16'b0, bus.stat_grant0}, 32'd0);
    chk("stat1_tied", {16'b0, bus.stat_grant1}, 32'd0);
`endif

    // Reset while a response is buffered: it is dropped.
    set_req(1, 32'h0000_00FF, 3'd0, 5'd8, 32'h0000_FF00, 1'b0);
    cyc(2'b10, 1'b0, 2'b10, "rdy_prerst");
    chk("prerst_valid", {31'b0, bus.resp_valid}, 32'h1);
    reset = 1'b1;
    bus.req_valid = 2'b00;
    sb.delete();
    @(posedge clk);
    #1;
    reset = 1'b0;
    chk("midrst_valid", {31'b0, bus.resp_valid}, 32'h0);
    chk("midrst_data", bus.resp_data, 32'h0);
    chk("midrst_stat0", {16'b0, bus.stat_grant0}, 32'h0);
    chk("midrst_stat1", {16'b0, bus.stat_grant1}, 32'h0);

    // Three grants to requester 1 after reset.
    set_req(1, 32'h0000_0080, 3'd1, 5'd7, 32'h0000_0001, 1'b0);
    for (int i = 0; i < 3; i++) cyc(2'b10, 1'b1, 2'b10, "rdy_post");
    cyc(2'b00, 1'b1, 2'b00, "rdy_idle4");
`ifdef SHIFT_ARB_STATS_EN
    chk("post_stat1", {16'b0, bus.stat_grant1}, 32'd3);
    chk("post_stat0", {16'b0, bus.stat_grant0}, 32'd0);
`else
    chk("post_stat1_tied", {16'b0, bus.stat_grant1}, 32'd0);
`endif

    chk("final_valid", {31'b0, bus.resp_valid}, 32'h0);
    chk("sb_empty", sb.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
